// File: rtl/lab5_pkg.sv
// Shared definitions for the lab5 summation datapath.
// Holds default geometry, the scheduler state encoding and the
// requester indices used by the two-way arbiter.
package lab5_pkg;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int DW    = 8;

  typedef enum logic [1:0] {IDLE, SUM, DRAIN, DONE} state_t;

  // bit positions in the arbiter request/grant vectors
  localparam logic REQ_HOST = 1'b0;
  localparam logic REQ_SEQ  = 1'b1;
endpackage

// File: rtl/mem_sum_sched_rr_arb2.sv
// rr_arb2: two-input round-robin arbiter.
// Ports:
//   clk, rst  - clock, synchronous active-low reset
//   req[1:0]  - requests, indexed by REQ_HOST / REQ_SEQ
//   gnt[1:0]  - one-hot (or zero) combinational grant
// A lone requester always wins. On contention the priority holder wins
// and priority passes to the other side; without contention it stays.
module rr_arb2
  import lab5_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  logic pri;  // index of the side holding priority

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt      = 2'b00;
      gnt[pri] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)               pri <= REQ_HOST;
    else if (req == 2'b11)  pri <= ~pri;
  end
endmodule

// File: rtl/mem_sum_sched.sv
// mem_sum_sched: owns the DEPTH x DW scratch memory and shares its single
// port between the host and a summation sequencer under round-robin
// arbitration.
// Ports:
//   clk, rst                  - clock, synchronous active-low reset
//   host_req/we/addr/din      - host access; held stable until host_gnt
//   host_gnt                  - combinational grant
//   host_dout, host_dvalid    - read data, valid the cycle after a granted read
//   start, base, len          - launch a wrap-around summation of len entries
//   busy, done, ans, ovf      - status, completion pulse, result, carry flag
// Optional build macro: SUM_SATURATE_EN - ans clamps at 2^DW-1 instead of
// wrapping; ovf behaves the same either way.
module mem_sum_sched
  import lab5_pkg::*;
#(
  parameter int DEPTH = lab5_pkg::DEPTH,
  parameter int AW    = lab5_pkg::AW,
  parameter int DW    = lab5_pkg::DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_din,
  output logic          host_gnt,
  output logic [DW-1:0] host_dout,
  output logic          host_dvalid,
  input  logic          start,
  input  logic [AW-1:0] base,
  input  logic [AW:0]   len,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] ans,
  output logic          ovf
);
  localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);

  state_t        state;
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rd_q;
  logic [AW-1:0] base_q;
  logic [AW:0]   len_q, issued;
  logic [DW-1:0] acc, acc_nxt;
  logic          acc_ovf;
  logic          seq_vld;  // rd_q holds sequencer data this cycle
  logic [1:0]    req, gnt;
  logic          seq_win;
  logic [AW-1:0] seq_addr, port_addr;
  logic [DW:0]   sum;

  // gate requests during reset so no grant is visible while rst is low
  always_comb begin
    req           = 2'b00;
    req[REQ_HOST] = rst & host_req;
    req[REQ_SEQ]  = rst & (state == SUM) & (issued < len_q);
  end

  rr_arb2 u_arb (.clk(clk), .rst(rst), .req(req), .gnt(gnt));

  assign host_gnt  = gnt[REQ_HOST];
  assign seq_win   = gnt[REQ_SEQ];
  assign seq_addr  = base_q + issued[AW-1:0];  // wraps mod DEPTH
  assign port_addr = seq_win ? seq_addr : host_addr;
  assign host_dout = rd_q;
  assign busy      = (state != IDLE);

  always_comb begin
    sum = {1'b0, acc} + {1'b0, rd_q};
`ifdef SUM_SATURATE_EN
    acc_nxt = sum[DW] ? '1 : sum[DW-1:0];
`else
    acc_nxt = sum[DW-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_q        <= '0;
      base_q      <= '0;
      len_q       <= '0;
      issued      <= '0;
      acc         <= '0;
      acc_ovf     <= 1'b0;
      seq_vld     <= 1'b0;
      host_dvalid <= 1'b0;
      ans         <= '0;
      ovf         <= 1'b0;
      done        <= 1'b0;
    end else begin
      host_dvalid <= host_gnt & ~host_we;
      seq_vld     <= seq_win;
      done        <= 1'b0;

      if (host_gnt && host_we)   mem[host_addr] <= host_din;
      else if (gnt != 2'b00)     rd_q <= mem[port_addr];

      if (seq_vld) begin
        acc <= acc_nxt;
        if (sum[DW]) acc_ovf <= 1'b1;
      end

      case (state)
        IDLE: if (start) begin
          base_q  <= base;
          len_q   <= (len > LEN_MAX) ? LEN_MAX : len;
          issued  <= '0;
          acc     <= '0;
          acc_ovf <= 1'b0;
          state   <= (len == '0) ? DONE : SUM;
        end
        SUM: if (seq_win) begin
          issued <= issued + 1'b1;
          if (issued + 1'b1 == len_q) state <= DRAIN;
        end
        // the last read's data is folded in at the edge leaving DRAIN
        DRAIN: if (seq_vld) state <= DONE;
        DONE: begin
          ans   <= acc;
          ovf   <= acc_ovf;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_sum_sched.sv
module tb_mem_sum_sched;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       host_req = 1'b0, host_we = 1'b0;
  logic [2:0] host_addr = '0;
  logic [7:0] host_din = '0;
  logic       host_gnt;
  logic [7:0] host_dout;
  logic       host_dvalid;
  logic       start = 1'b0;
  logic [2:0] base = '0;
  logic [3:0] len = '0;
  logic       busy, done, ovf;
  logic [7:0] ans;

  int tests = 0, fails = 0;
  int mem_m [8];
  bit prio_host = 1'b1;  // which side wins the next contended cycle
  bit watch = 1'b0;
  int dv_cnt = 0;

  mem_sum_sched dut (
    .clk(clk), .rst(rst), .host_req(host_req), .host_we(host_we),
    .host_addr(host_addr), .host_din(host_din), .host_gnt(host_gnt),
    .host_dout(host_dout), .host_dvalid(host_dvalid), .start(start),
    .base(base), .len(len), .busy(busy), .done(done), .ans(ans), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // host reads during the contended run must all return the model value
  always begin
    @(posedge clk); #1;
    if (watch && host_dvalid) begin
      dv_cnt++;
      chk("cont_dout", host_dout, mem_m[5]);
    end
  end

  task automatic host_access(input bit we, input int addr, input int din, input string tag);
    int n = 0;
    host_req = 1'b1; host_we = we; host_addr = 3'(addr); host_din = 8'(din);
    #1;
    while (!host_gnt && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, "_gnt"}, host_gnt, 1);
    tick();
    host_req = 1'b0;
    if (we) mem_m[addr] = din;
    else begin
      chk({tag, "_dv"}, host_dvalid, 1);
      chk({tag, "_dout"}, host_dout, mem_m[addr]);
    end
  endtask

  // reference: plain sum over the wrap-around window
  task automatic model(input int b, input int l, output int a, output int o, output int lc);
    int tot = 0;
    lc = (l > 8) ? 8 : l;
    for (int i = 0; i < lc; i++) tot += mem_m[(b + i) % 8];
    o = (tot > 255);
`ifdef SUM_SATURATE_EN
    a = (tot > 255) ? 255 : tot;
`else
    a = tot % 256;
`endif
  endtask

  task automatic run_sum(input int b, input int l, input int pulse_at, input bit contend,
                         input string tag);
    int ea, eo, lc, ecyc, lost, cnt;
    model(b, l, ea, eo, lc);
    lost = 0;
    if (contend && lc > 0) begin
      lost = prio_host ? lc : lc - 1;
      prio_host = 1'b1;
    end
    ecyc = (lc == 0) ? 1 : lc + 2 + lost;
    start = 1'b1; base = 3'(b); len = 4'(l);
    tick();
    start = 1'b0;
    chk({tag, "_busy"}, busy, 1);
    cnt = 0;
    while (cnt < 200) begin
      tick(); cnt++;
      start = (cnt == pulse_at);
      base = 3'd3; len = 4'd1;
      if (done) break;
    end
    start = 1'b0;
    chk({tag, "_cyc"}, cnt, ecyc);
    chk({tag, "_ans"}, ans, ea);
    chk({tag, "_ovf"}, ovf, eo);
    tick();
    chk({tag, "_done_clr"}, done, 0);
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    int a, n;
    for (int i = 0; i < 8; i++) mem_m[i] = 0;
    repeat (2) tick();
    host_req = 1'b1;
    #1;
    chk("rst_gnt", host_gnt, 0);
    host_req = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ans", ans, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_dv", host_dvalid, 0);
    chk("rst_dout", host_dout, 0);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) host_access(1'b1, i, 10 * (i + 1), "ld");
    host_access(1'b0, 3, 0, "rd3");
    run_sum(0, 6, -1, 1'b0, "sum6");
    run_sum(0, 6, 3, 1'b0, "busy_start");

    host_req = 1'b1; host_we = 1'b0; host_addr = 3'd5;
    watch = 1'b1; dv_cnt = 0;
    run_sum(0, 6, -1, 1'b1, "cont");
    watch = 1'b0; host_req = 1'b0;
    chk("cont_dv_seen", (dv_cnt >= 6), 1);

    run_sum(2, 0, -1, 1'b0, "len0");

    host_access(1'b1, 6, 70, "ld6");
    host_access(1'b1, 7, 80, "ld7");
    run_sum(6, 4, -1, 1'b0, "wrap");

    for (int i = 0; i < 3; i++) host_access(1'b1, i, 100, "ld100");
    run_sum(0, 3, -1, 1'b0, "ovf");

    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 8; i++) host_access(1'b1, i, int'($urandom_range(0, 255)), "rnd_ld");
      run_sum(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)), -1, 1'b0, "rnd");
    end

    // abort mid-run
    for (int i = 0; i < 8; i++) host_access(1'b1, i, 10 * (i + 1), "ld_ab");
    run_sum(0, 6, -1, 1'b0, "pre_ab");
    start = 1'b1; base = 3'd0; len = 4'd6;
    tick();
    start = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    for (int i = 0; i < 8; i++) mem_m[i] = 0;
    prio_host = 1'b1;
    chk("ab_busy", busy, 0);
    chk("ab_ans", ans, 0);
    chk("ab_ovf", ovf, 0);
    chk("ab_done", done, 0);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) n++;
    end
    chk("ab_no_done", n, 0);
    a = int'($urandom_range(0, 7));
    host_access(1'b0, a, 0, "ab_rd");
    host_access(1'b0, 5, 0, "ab_rd5");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
